// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit returning {hi_o, lo_o}.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-stage product.
module muldiv_unit #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned DIV_RADIX_LOG2 = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   input  logic             flush_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CntW     = $clog2(WIDTH + 1);
   localparam int unsigned DivIters = WIDTH / DIV_RADIX_LOG2;
   localparam logic [CntW-1:0] MulLast = CntW'(WIDTH - 1);
   localparam logic [CntW-1:0] DivLast = CntW'(DivIters - 1);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StPrep = 3'd1;
   localparam logic [2:0] StCalc = 3'd2;
   localparam logic [2:0] StFix  = 3'd3;
   localparam logic [2:0] StDone = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
   logic [CntW-1:0]  cnt_q;
   logic             neg_q_q, neg_r_q;
   logic [WIDTH-1:0] hi_q, lo_q;

   logic             is_div, is_signed, accept;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] div_rem, div_quo;
   logic [WIDTH:0]   div_trial;
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH-1:0] fix_quo, fix_rem;

   assign is_div    = op_q[1];
   assign is_signed = ~op_q[0];
   assign ready_o   = (state_q == StIdle) || (state_q == StDone);
   assign busy_o    = (state_q == StPrep) || (state_q == StCalc) || (state_q == StFix);
   assign done_o    = (state_q == StDone);
   assign hi_o      = hi_q;
   assign lo_o      = lo_q;
   assign accept    = ready_o && start_i && !flush_i;

   assign a_abs = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
   assign b_abs = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

   // One shift-add step: {carry, hi, lo} shifted right after a conditional add.
   assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : {(WIDTH + 1){1'b0}});

   // Restoring divide: DIV_RADIX_LOG2 quotient bits per cycle. With b=0 every trial succeeds,
   // which yields q=all-ones and r=dividend without a special case.
   always_comb begin
      div_rem   = acc_hi_q;
      div_quo   = acc_lo_q;
      div_trial = '0;
      for (int i = 0; i < int'(DIV_RADIX_LOG2); i++) begin
         div_trial = {div_rem, div_quo[WIDTH-1]};
         div_quo   = {div_quo[WIDTH-2:0], 1'b0};
         if (div_trial >= {1'b0, b_q}) begin
            div_trial  = div_trial - {1'b0, b_q};
            div_quo[0] = 1'b1;
         end
         div_rem = div_trial[WIDTH-1:0];
      end
   end

   always_comb begin
`ifdef MULDIV_FAST_MUL_EN
      mul_res = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`else
      mul_res = {acc_hi_q, acc_lo_q};
`endif
      if (neg_q_q) mul_res = -mul_res;
      fix_quo = neg_q_q ? -acc_lo_q : acc_lo_q;
      fix_rem = neg_r_q ? -acc_hi_q : acc_hi_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (accept) state_d = StPrep;
         StPrep: begin
            if (flush_i) state_d = StIdle;
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) state_d = StFix;
`endif
            else state_d = StCalc;
         end
         StCalc: begin
            if (flush_i) state_d = StIdle;
            else if (cnt_q == (is_div ? DivLast : MulLast)) state_d = StFix;
         end
         StFix:  state_d = flush_i ? StIdle : StDone;
         StDone: state_d = accept ? StPrep : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q <= op_i;
            a_q  <= operand_a_i;
            b_q  <= operand_b_i;
         end
         case (state_q)
            StPrep: begin
               a_q      <= a_abs;
               b_q      <= b_abs;
               neg_q_q  <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               neg_r_q  <= is_signed && a_q[WIDTH-1];
               acc_hi_q <= '0;
               acc_lo_q <= is_div ? a_abs : b_abs;
               cnt_q    <= '0;
            end
            StCalc: begin
               cnt_q <= cnt_q + CntW'(1);
               if (is_div) begin
                  acc_hi_q <= div_rem;
                  acc_lo_q <= div_quo;
               end else begin
                  acc_hi_q <= mul_sum[WIDTH:1];
                  acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
               end
            end
            StFix: begin
               if (!flush_i) begin
                  hi_q <= is_div ? fix_rem : mul_res[2*WIDTH-1:WIDTH];
                  lo_q <= is_div ? fix_quo : mul_res[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: radix-2 instance plus a radix-4 divider instance.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MulLat = 2;
`else
   localparam int MulLat = 34;
`endif
   localparam int DivLat  = 34;
   localparam int Div4Lat = 18;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start2, flush;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        ready, busy, done, ready2, busy2, done2;
   logic [31:0] hi, lo, hi2, lo2;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [63:0] sb[$];
   logic [63:0] sb2[$];

   muldiv_unit #(.WIDTH(32), .DIV_RADIX_LOG2(1)) dut (
      .clk(clk), .rst(rst), .start_i(start), .op_i(op), .operand_a_i(a), .operand_b_i(b),
      .flush_i(flush), .ready_o(ready), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
   );

   muldiv_unit #(.WIDTH(32), .DIV_RADIX_LOG2(2)) dut4 (
      .clk(clk), .rst(rst), .start_i(start2), .op_i(op), .operand_a_i(a), .operand_b_i(b),
      .flush_i(1'b0), .ready_o(ready2), .busy_o(busy2), .done_o(done2), .hi_o(hi2), .lo_o(lo2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboards: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b1 && done === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_done: got hi=%h lo=%h, required no done", hi, lo);
         end else if ({hi, lo} !== sb[0]) begin
            n_fail++;
            $display("FAIL sb_result: got %h_%h required %h_%h", hi, lo, sb[0][63:32], sb[0][31:0]);
            void'(sb.pop_front());
         end else void'(sb.pop_front());
      end
      if (rst === 1'b1 && done2 === 1'b1) begin
         n_checks++;
         if (sb2.size() == 0) begin
            n_fail++;
            $display("FAIL sb4_unexpected_done: got hi=%h lo=%h, required no done", hi2, lo2);
         end else if ({hi2, lo2} !== sb2[0]) begin
            n_fail++;
            $display("FAIL sb4_result: got %h_%h required %h_%h", hi2, lo2, sb2[0][63:32],
                     sb2[0][31:0]);
            void'(sb2.pop_front());
         end else void'(sb2.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                         input logic [31:0] mb);
      logic signed [63:0] sa, sbv, q, r;
      logic [63:0] ua, ub;
      sa  = {{32{ma[31]}}, ma};
      sbv = {{32{mb[31]}}, mb};
      ua  = {32'd0, ma};
      ub  = {32'd0, mb};
      case (mop)
         2'b00: return sa * sbv;
         2'b01: return ua * ub;
         2'b10: begin
            if (mb == 32'd0) return {ma, (ma[31] ? 32'd1 : 32'hFFFF_FFFF)};
            q = sa / sbv;
            r = sa % sbv;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (mb == 32'd0) return {ma, 32'hFFFF_FFFF};
            q = ua / ub;
            r = ua % ub;
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   task automatic send(input bit which, input logic [1:0] sop, input logic [31:0] sa,
                       input logic [31:0] sbv, input logic [63:0] exp, output int t_acc);
      @(negedge clk);
      op = sop;
      a  = sa;
      b  = sbv;
      if (which) begin
         start2 = 1'b1;
         sb2.push_back(exp);
      end else begin
         start = 1'b1;
         sb.push_back(exp);
      end
      @(posedge clk);
      #1;
      t_acc  = cyc;
      start  = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic wait_done(input bit which, output int t_done);
      int n = 0;
      while ((which ? done2 : done) !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      t_done = ((which ? done2 : done) === 1'b1) ? cyc : -1000;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got r/b/d=%b%b%b required 100", ready, busy, done);
      end
      n_checks++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_result: got %h_%h required 0_0", hi, lo);
      end
      n_checks++;
      if (ready2 !== 1'b1 || busy2 !== 1'b0 || hi2 !== 32'd0 || lo2 !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_dut4: got ready=%b busy=%b hi=%h lo=%h required 1 0 0 0",
                  ready2, busy2, hi2, lo2);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_mul();
      int t0, t1;
      logic [31:0] ra, rb;
      send(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, t0);
      n_checks++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_busy_after_accept: got busy=%b ready=%b required 1 0", busy, ready);
      end
      wait_done(0, t1);
      n_checks++;
      if (t1 - t0 !== MulLat) begin
         n_fail++;
         $display("FAIL multu_latency: got %0d required %0d", t1 - t0, MulLat);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL done_single_pulse: got done=%b ready=%b busy=%b required 0 1 0",
                  done, ready, busy);
      end
      send(0, 2'b00, -32'sd3, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, t0);
      wait_done(0, t1);
      n_checks++;
      if (t1 - t0 !== MulLat) begin
         n_fail++;
         $display("FAIL mult_latency: got %0d required %0d", t1 - t0, MulLat);
      end
      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         rb = $urandom;
         send(0, 2'(i % 2), ra, rb, model(2'(i % 2), ra, rb), t0);
         wait_done(0, t1);
         n_checks++;
         if (t1 - t0 !== MulLat) begin
            n_fail++;
            $display("FAIL mul_rand_latency: got %0d required %0d", t1 - t0, MulLat);
         end
      end
   endtask

   task automatic test_div();
      int t0, t1;
      logic [31:0] ra, rb;
      logic [1:0]  vop[4] = '{2'b10, 2'b11, 2'b10, 2'b10};
      logic [31:0] va[4]  = '{-32'sd7, 32'd100, 32'h8000_0000, -32'sd5};
      logic [31:0] vb[4]  = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
      logic [63:0] ve[4]  = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd100, 32'hFFFF_FFFF},
                              {32'd0, 32'h8000_0000}, {32'hFFFF_FFFB, 32'd1}};
      for (int i = 0; i < 4; i++) begin
         send(0, vop[i], va[i], vb[i], ve[i], t0);
         wait_done(0, t1);
         n_checks++;
         if (t1 - t0 !== DivLat) begin
            n_fail++;
            $display("FAIL div_vec%0d_latency: got %0d required %0d", i, t1 - t0, DivLat);
         end
      end
      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         rb = (i == 3) ? 32'($urandom_range(1, 9)) : $urandom >> $urandom_range(0, 24);
         send(0, 2'(2 + i % 2), ra, rb, model(2'(2 + i % 2), ra, rb), t0);
         wait_done(0, t1);
      end
   endtask

   task automatic test_flush();
      int t0, t1, seen;
      send(0, 2'b11, 32'd50, 32'd7, {32'd1, 32'd7}, t0);
      wait_done(0, t1);
      send(0, 2'b10, 32'd1000, 32'd3, 64'd0, t0);
      void'(sb.pop_back());
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_to_idle: got r/b/d=%b%b%b required 100", ready, busy, done);
      end
      n_checks++;
      if (hi !== 32'd1 || lo !== 32'd7) begin
         n_fail++;
         $display("FAIL flush_keeps_result: got %h_%h required 1_7", hi, lo);
      end
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL flush_no_done: got %0d done cycles required 0", seen);
      end
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_beats_start: got busy=%b ready=%b required 0 1", busy, ready);
      end
   endtask

   task automatic test_back_to_back();
      int t0, t1, t2, t3;
      send(0, 2'b10, 32'h7FFF_FFF0, 32'd13, model(2'b10, 32'h7FFF_FFF0, 32'd13), t0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      op    = 2'b01;
      a     = 32'd0;
      b     = 32'd1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_in_calc_ignored: got busy=%b required 1", busy);
      end
      wait_done(0, t1);
      n_checks++;
      if (t1 - t0 !== DivLat) begin
         n_fail++;
         $display("FAIL b2b_first_latency: got %0d required %0d", t1 - t0, DivLat);
      end
      send(0, 2'b11, 32'd12345, 32'd67, {32'd17, 32'd184}, t2);
      n_checks++;
      if (t2 !== t1 + 1) begin
         n_fail++;
         $display("FAIL b2b_accept_in_done: got accept at %0d required %0d", t2, t1 + 1);
      end
      wait_done(0, t3);
      n_checks++;
      if (t3 - t2 !== DivLat) begin
         n_fail++;
         $display("FAIL b2b_second_latency: got %0d required %0d", t3 - t2, DivLat);
      end
   endtask

   task automatic test_radix4();
      int t0, t1;
      logic [31:0] ra, rb;
      send(1, 2'b11, 32'd1000, 32'd7, {32'd6, 32'd142}, t0);
      wait_done(1, t1);
      n_checks++;
      if (t1 - t0 !== Div4Lat) begin
         n_fail++;
         $display("FAIL radix4_latency: got %0d required %0d", t1 - t0, Div4Lat);
      end
      for (int i = 0; i < 3; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(4, 28);
         send(1, 2'b10, ra, rb, model(2'b10, ra, rb), t0);
         wait_done(1, t1);
      end
   endtask

   task automatic test_async_reset();
      int t0, t1;
      send(0, 2'b10, 32'd999, 32'd4, 64'd0, t0);
      repeat (6) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      sb.delete();
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_flags: got r/b/d=%b%b%b required 100", ready, busy, done);
      end
      n_checks++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         n_fail++;
         $display("FAIL async_reset_result: got %h_%h required 0_0", hi, lo);
      end
      @(negedge clk);
      rst = 1'b1;
      send(0, 2'b01, 32'd3, 32'd5, {32'd0, 32'd15}, t0);
      wait_done(0, t1);
      n_checks++;
      if (t1 - t0 !== MulLat) begin
         n_fail++;
         $display("FAIL post_reset_latency: got %0d required %0d", t1 - t0, MulLat);
      end
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      start2 = 1'b0;
      flush  = 1'b0;
      op     = 2'b00;
      a      = '0;
      b      = '0;
      #2;
      rst = 1'b0;
      test_reset();
      test_mul();
      test_div();
      test_flush();
      test_back_to_back();
      test_radix4();
      test_async_reset();
      repeat (3) @(posedge clk);
      n_checks++;
      if (sb.size() != 0 || sb2.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drained: got %0d/%0d pending required 0/0", sb.size(), sb2.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
